// File: rtl/ising_logic_pkg.sv
// Shared configuration, derived geometry and FSM encoding for the
// Ising L1 row packer and its address decoder.
package ising_logic_pkg;

  typedef struct packed {
    int unsigned num_spin;
    int unsigned bit_j;
  } ising_logic_cfg_t;

  localparam ising_logic_cfg_t IsingLogicCfg = '{num_spin: 256, bit_j: 4};
  localparam int unsigned LagdDataWidth = 64;

  typedef enum logic [1:0] {
    StFill,
    StFlush,
    StRsp
  } pack_state_e;

  function automatic ising_logic_cfg_t make_cfg(
    input int unsigned num_spin,
    input int unsigned bit_j
  );
    ising_logic_cfg_t cfg;
    cfg.num_spin = num_spin;
    cfg.bit_j    = bit_j;
    return cfg;
  endfunction

  function automatic int unsigned row_width(input ising_logic_cfg_t cfg);
    return cfg.num_spin * cfg.bit_j;
  endfunction

  function automatic int unsigned beats_per_row(
    input ising_logic_cfg_t cfg,
    input int unsigned      data_width
  );
    return row_width(cfg) / data_width;
  endfunction

endpackage

// File: rtl/ising_l1_addr_dec.sv
// Combinational decode of a bus write into row/beat and a legality flag
// checked against the current fill position of the row buffer.
module ising_l1_addr_dec
  import ising_logic_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned NumSpin    = 256,
  parameter int unsigned BitJ       = 4,
  parameter int unsigned BaseAddr   = 0,
  parameter int unsigned WindowSize = 'h1_0000,
  localparam int unsigned RowW      = row_width(make_cfg(NumSpin, BitJ)),
  localparam int unsigned Beats     =
    beats_per_row(make_cfg(NumSpin, BitJ), DataWidth),
  localparam int unsigned RowIdxW   = $clog2(NumSpin),
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth/8-1:0] strb_i,
  input  logic [BeatW-1:0]       cnt_i,
  input  logic [RowIdxW-1:0]     buf_row_i,
  output logic [RowIdxW-1:0]     row_o,
  output logic [BeatW-1:0]       beat_o,
  output logic                   final_o,
  output logic                   err_o
);

  localparam int unsigned Bpb  = DataWidth / 8;
  localparam int unsigned RowB = RowW / 8;

  localparam logic [AddrWidth-1:0] BaseA = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth-1:0] WinA  = AddrWidth'(WindowSize);
  localparam logic [AddrWidth-1:0] RowBA = AddrWidth'(RowB);
  localparam logic [AddrWidth-1:0] BpbA  = AddrWidth'(Bpb);
  localparam logic [AddrWidth-1:0] NsA   = AddrWidth'(NumSpin);
  localparam logic [AddrWidth-1:0] LastA = AddrWidth'(Beats - 1);

  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] row_full;
  logic [AddrWidth-1:0] beat_full;
  logic                 range_err;
  logic                 fmt_err;
  logic                 seq_err;

  always_comb begin
    off       = addr_i - BaseA;
    row_full  = off / RowBA;
    beat_full = (off % RowBA) / BpbA;
    row_o     = row_full[RowIdxW-1:0];
    beat_o    = beat_full[BeatW-1:0];
    final_o   = (beat_full == LastA);
    range_err = (addr_i < BaseA) || (off >= WinA) || (row_full >= NsA);
    fmt_err   = ((addr_i % BpbA) != '0) || (strb_i != '1);
    // beats must arrive in order and all belong to the buffered row
    seq_err   = (beat_full != AddrWidth'(cnt_i)) ||
                ((cnt_i != '0) && (row_o != buf_row_i));
    err_o     = range_err || fmt_err || seq_err;
  end

endmodule

// File: rtl/ising_l1_row_packer.sv
// Packs sequential bus write beats into full J-memory rows and hands each
// completed row off before answering the bus with a write response.
module ising_l1_row_packer
  import ising_logic_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned NumSpin    = 256,
  parameter int unsigned BitJ       = 4,
  parameter int unsigned BaseAddr   = 0,
  parameter int unsigned WindowSize = 'h1_0000,
  localparam int unsigned RowW      = row_width(make_cfg(NumSpin, BitJ)),
  localparam int unsigned Beats     =
    beats_per_row(make_cfg(NumSpin, BitJ), DataWidth),
  localparam int unsigned RowIdxW   = $clog2(NumSpin),
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_err_o,
  output logic                   row_valid_o,
  input  logic                   row_ready_i,
  output logic [RowIdxW-1:0]     row_idx_o,
  output logic [RowW-1:0]        row_data_o,
  output logic                   partial_o
);

  if (RowW % DataWidth != 0) begin : g_chk_row_w
    $error("row width must be a whole number of bus beats");
  end

  if (NumSpin * (RowW / 8) > WindowSize) begin : g_chk_window
    $error("J memory does not fit in the L1 window");
  end

  pack_state_e          state_q, state_d;
  logic [BeatW-1:0]     cnt_q, cnt_d;
  logic [RowIdxW-1:0]   row_q, row_d;
  logic [RowW-1:0]      buf_q, buf_d;
  logic                 err_q, err_d;

  logic [BeatW-1:0]     cnt_eff;
  logic [RowIdxW-1:0]   dec_row;
  logic [BeatW-1:0]     dec_beat;
  logic                 dec_final;
  logic                 dec_err;

  // a same-cycle clear restarts the row before the request is judged
  assign cnt_eff = clear_i ? '0 : cnt_q;

  ising_l1_addr_dec #(
    .DataWidth  (DataWidth),
    .AddrWidth  (AddrWidth),
    .NumSpin    (NumSpin),
    .BitJ       (BitJ),
    .BaseAddr   (BaseAddr),
    .WindowSize (WindowSize)
  ) u_addr_dec (
    .addr_i    (req_addr_i),
    .strb_i    (req_strb_i),
    .cnt_i     (cnt_eff),
    .buf_row_i (row_q),
    .row_o     (dec_row),
    .beat_o    (dec_beat),
    .final_o   (dec_final),
    .err_o     (dec_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      StFill: begin
        cnt_d = cnt_eff;
        if (req_valid_i) begin
          state_d = StRsp;
          err_d   = dec_err;
          if (!dec_err) begin
            buf_d[dec_beat*DataWidth +: DataWidth] = req_data_i;
            row_d = dec_row;
            if (dec_final) begin
              state_d = StFlush;
            end else begin
              cnt_d = cnt_eff + BeatW'(1);
            end
          end
        end
      end
      StFlush: begin
        if (row_ready_i) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StRsp;
        end
      end
      StRsp: begin
        cnt_d = cnt_eff;
        if (rsp_ready_i) begin
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFill;
      cnt_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == StFill) && !rst_i;
  assign rsp_valid_o = (state_q == StRsp);
  assign rsp_err_o   = (state_q == StRsp) && err_q;
  assign row_valid_o = (state_q == StFlush);
  assign row_idx_o   = row_q;
  assign row_data_o  = buf_q;
  assign partial_o   = (cnt_q != '0);

endmodule

// File: tb/tb_ising_l1_row_packer.sv
// Directed tables, hand sequences and random traffic against a
// beat-array reference model of the row packer.
module tb_ising_l1_row_packer;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 48;
  localparam int unsigned NS    = 256;
  localparam int unsigned BJ    = 4;
  localparam int unsigned ROWW  = NS * BJ;
  localparam int unsigned RB    = ROWW / 8;
  localparam int unsigned BEATS = ROWW / DW;
  localparam int unsigned WIN   = 'h1_0000;
  localparam longint      BASE  = 64'h2000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_data = '0;
  logic [DW/8-1:0] req_strb = '0;
  logic            rsp_valid_o;
  logic            rsp_ready = 1'b0;
  logic            rsp_err_o;
  logic            row_valid_o;
  logic            row_ready = 1'b0;
  logic [7:0]      row_idx_o;
  logic [ROWW-1:0] row_data_o;
  logic            partial_o;

  int n_chk = 0;
  int n_fail = 0;

  int          m_cnt = 0;
  int          m_row = 0;
  logic [63:0] m_beats [BEATS];

  always #5 clk = ~clk;

  ising_l1_row_packer #(
    .DataWidth  (DW),
    .AddrWidth  (AW),
    .NumSpin    (NS),
    .BitJ       (BJ),
    .BaseAddr   (32'h2000_0000),
    .WindowSize (WIN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_err_o   (rsp_err_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready),
    .row_idx_o   (row_idx_o),
    .row_data_o  (row_data_o),
    .partial_o   (partial_o)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_row(input string nm, input logic [ROWW-1:0] exp);
    n_chk++;
    if (row_data_o !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, row_data_o, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_row = 0;
    for (int k = 0; k < BEATS; k++) m_beats[k] = '0;
  endtask

  // returns whether the write is rejected and whether it completes a row
  task automatic model_apply(input logic [AW-1:0] a, input logic [63:0] d,
                             input logic [7:0] s, input bit clr,
                             output bit err, output bit fin);
    longint off, row, beat;
    if (clr) m_cnt = 0;
    err = 1'b0;
    fin = 1'b0;
    off = longint'(a) - BASE;
    if (off < 0 || off >= longint'(WIN)) begin
      err = 1'b1;
    end else begin
      row  = off / RB;
      beat = (off % RB) / 8;
      if (row >= NS || (longint'(a) % 8) != 0 || s != 8'hFF ||
          beat != longint'(m_cnt) ||
          (m_cnt != 0 && row != longint'(m_row)))
        err = 1'b1;
      if (!err) begin
        m_beats[beat] = d;
        m_row = int'(row);
        if (beat == BEATS - 1) fin = 1'b1;
        else m_cnt++;
      end
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [63:0] d,
                      input logic [7:0] s, input bit clr, input int stall,
                      output bit got_err, output bit got_part);
    bit e, f;
    logic [ROWW-1:0] exp_row;
    logic [ROWW-1:0] held;
    model_apply(a, d, s, clr, e, f);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    clear     = clr;
    @(negedge clk);
    req_valid = 1'b0;
    clear     = 1'b0;
    if (f) begin
      for (int k = 0; k < BEATS; k++) exp_row[k*64 +: 64] = m_beats[k];
      chk("row_valid", row_valid_o, 1);
      chk("rsp_valid_in_flush", rsp_valid_o, 0);
      chk("req_ready_in_flush", req_ready_o, 0);
      chk("row_idx", row_idx_o, 64'(m_row));
      chk_row("row_data", exp_row);
      held = row_data_o;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("row_valid_hold", row_valid_o, 1);
        chk("rsp_valid_stall", rsp_valid_o, 0);
        chk_row("row_data_stable", held);
      end
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      m_cnt = 0;
      chk("rsp_after_row", rsp_valid_o, 1);
      chk("row_valid_drop", row_valid_o, 0);
      chk("rsp_err_row", rsp_err_o, 0);
    end else begin
      chk("rsp_valid", rsp_valid_o, 1);
      chk("row_valid_idle", row_valid_o, 0);
      chk("rsp_err", rsp_err_o, 64'(e));
    end
    got_err  = rsp_err_o;
    got_part = partial_o;
    chk("partial", partial_o, 64'(m_cnt != 0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", rsp_valid_o, 1);
      chk("rsp_err_hold", rsp_err_o, got_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid_o, 0);
    chk("req_ready_back", req_ready_o, 1);
  endtask

  function automatic logic [AW-1:0] adr(input int row, input int beat);
    return AW'(BASE + longint'(row) * RB + longint'(beat) * 8);
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [7:0]    strb;
    bit            clr;
    bit            exp_err;
    bit            exp_part;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit ge, gp;
    model_reset();
    tbl.push_back('{48'h2001_0000, 64'h1, 8'hFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{48'h2000_0004, 64'h2, 8'hFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{48'h2000_0000, 64'h3, 8'h0F, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{48'h2000_0000, 64'h10, 8'hFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{48'h2000_0008, 64'h11, 8'hFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{48'h2000_0018, 64'h13, 8'hFF, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{48'h2000_0010, 64'h12, 8'hFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{48'h2000_0098, 64'h14, 8'hFF, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{48'h1FFF_FFF8, 64'h15, 8'hFF, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{48'h2000_8000, 64'h16, 8'hFF, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{48'h2000_0280, 64'h17, 8'hFF, 1'b0, 1'b0, 1'b1});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_row_valid", row_valid_o, 0);
    chk("rst_row_idx", row_idx_o, 0);
    chk("rst_partial", partial_o, 0);
    chk_row("rst_row_data", '0);

    foreach (tbl[i]) begin
      send(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].clr, 0, ge, gp);
      chk($sformatf("tbl%0d_err", i), ge, tbl[i].exp_err);
      chk($sformatf("tbl%0d_partial", i), gp, tbl[i].exp_part);
    end

    // row 3 half-filled, dropped by a standalone clear, then row 5 starts
    send(adr(3, 0), 64'h300, 8'hFF, 1'b1, 0, ge, gp);
    for (int k = 1; k < 8; k++)
      send(adr(3, k), 64'h300 + 64'(k), 8'hFF, 1'b0, 0, ge, gp);
    chk("r3_partial", partial_o, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_cnt = 0;
    chk("clear_partial", partial_o, 0);
    send(adr(5, 0), 64'h500, 8'hFF, 1'b0, 0, ge, gp);
    chk("r5_b0_err", ge, 0);
    chk("r5_b0_partial", gp, 1);
    for (int k = 1; k < BEATS; k++)
      send(adr(5, k), 64'h500 + 64'(k), 8'hFF, 1'b0, 0, ge, gp);

    // full row 1, data equals beat index, no back-pressure
    for (int k = 0; k < BEATS; k++) begin
      send(adr(1, k), 64'(k), 8'hFF, 1'b0, 0, ge, gp);
      chk($sformatf("r1_b%0d_err", k), ge, 0);
    end

    // row 2 final beat held off by the J memory for five cycles
    for (int k = 0; k < BEATS; k++)
      send(adr(2, k), 64'hABCD_0000 + 64'(k), 8'hFF, 1'b0,
           (k == BEATS - 1) ? 5 : 0, ge, gp);

    for (int it = 0; it < 700; it++) begin
      int r, row, beat, stall;
      logic [AW-1:0] a;
      logic [7:0]    s;
      bit            clr;
      r     = int'($urandom_range(0, 99));
      row   = (m_cnt != 0 && r < 93) ? m_row : int'($urandom_range(0, NS - 1));
      beat  = (r < 92) ? m_cnt : int'($urandom_range(0, BEATS - 1));
      a     = adr(row, beat);
      s     = 8'hFF;
      if (r == 95) a = a + 48'd4;
      if (r == 96) a = AW'(BASE + longint'(WIN) + 8);
      if (r == 97) a = AW'(BASE - 8);
      if (r == 98) s = 8'($urandom_range(0, 254));
      if (r == 99) a = adr(NS + int'($urandom_range(0, 7)), 0);
      clr   = ($urandom_range(0, 39) == 0);
      stall = int'($urandom_range(0, 3));
      send(a, {$urandom, $urandom}, s, clr, stall, ge, gp);
    end

    // reset while a finished row waits in the flush state
    send(adr(4, 0), 64'h400, 8'hFF, 1'b1, 0, ge, gp);
    for (int k = 1; k < BEATS - 1; k++)
      send(adr(4, k), 64'h400 + 64'(k), 8'hFF, 1'b0, 0, ge, gp);
    req_valid = 1'b1;
    req_addr  = adr(4, BEATS - 1);
    req_data  = 64'h4FF;
    req_strb  = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("r4_row_valid", row_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_flush_row_valid", row_valid_o, 0);
    chk("rst_flush_partial", partial_o, 0);
    chk("rst_flush_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_req_ready", req_ready_o, 1);
    chk("post_rst_rsp_valid", rsp_valid_o, 0);
    chk("post_rst_row_valid", row_valid_o, 0);
    send(adr(7, 0), 64'h700, 8'hFF, 1'b0, 0, ge, gp);
    chk("post_rst_err", ge, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
